// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bundle: branch redirect, instruction-memory request/response and
// the decode-facing queue head. master = the prefetch queue, slave = its environment.
interface fetch_prefetch_queue_if #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] imem_rdata;
    logic              imem_resp;
    logic              imem_retry;
    logic [WORD_W-1:0] imem_address;
    logic              imem_action_stb;
    logic              imem_action_cyc;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    logic [CNT_W-1:0]  count;

    modport master (
        input  redirect, redirect_pc, imem_rdata, imem_resp, imem_retry, out_ready,
        output imem_address, imem_action_stb, imem_action_cyc,
               out_valid, out_instr, out_pc, count
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, imem_resp, imem_retry, out_ready,
        input  imem_address, imem_action_stb, imem_action_cyc,
               out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM feeding a circular
// buffer of {instr, pc+2} entries, flushed on redirect.
module fetch_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                WORD_W   = 16,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } entry_t;

    entry_t            queue [DEPTH];
    state_t            state, state_nxt;
    logic [WORD_W-1:0] addr_q, addr_nxt, fetch_pc, fetch_pc_nxt;
    logic [WORD_W-1:0] addr_inc, rpc;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              flush, enq, deq, room, room_nxt;

    assign rpc      = bus.redirect_pc & ~WORD_W'(1);
    assign addr_inc = addr_q + WORD_W'(2);
    assign flush    = bus.redirect;
    assign enq      = (state == REQ) && bus.imem_resp && !bus.redirect;
    assign deq      = bus.out_valid && bus.out_ready;

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (enq && !deq)
            count_nxt = count + CNT_W'(1);
        else if (deq && !enq)
            count_nxt = count - CNT_W'(1);
    end

    assign room     = count < CNT_W'(DEPTH);
    assign room_nxt = count_nxt < CNT_W'(DEPTH);

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        fetch_pc_nxt = fetch_pc;
        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    state_nxt    = REQ;
                    addr_nxt     = rpc;
                    fetch_pc_nxt = rpc;
                end else if (room) begin
                    state_nxt = REQ;
                    addr_nxt  = fetch_pc;
                end
            end
            REQ: begin
                if (bus.imem_resp && bus.redirect) begin
                    state_nxt    = REQ;
                    addr_nxt     = rpc;
                    fetch_pc_nxt = rpc;
                end else if (bus.imem_resp) begin
                    fetch_pc_nxt = addr_inc;
                    // Chain straight into the next fetch so a streaming cache sees no bubble
                    if (room_nxt) begin
                        state_nxt = REQ;
                        addr_nxt  = addr_inc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (bus.redirect) begin
                    fetch_pc_nxt = rpc;
                    state_nxt    = DROP;
                end else if (bus.imem_retry) begin
                    state_nxt = REQ;
                end
            end
            DROP: begin
                // The stale request must complete before the redirected one is issued
                if (bus.imem_resp) begin
                    state_nxt    = REQ;
                    addr_nxt     = bus.redirect ? rpc : fetch_pc;
                    fetch_pc_nxt = bus.redirect ? rpc : fetch_pc;
                end else if (bus.redirect) begin
                    fetch_pc_nxt = rpc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= RESET_PC;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            rd_ptr   <= flush ? '0 : rd_ptr + PTR_W'(deq);
            wr_ptr   <= flush ? '0 : wr_ptr + PTR_W'(enq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            queue[wr_ptr] <= '{instr: bus.imem_rdata, pc: addr_inc};
    end

    assign bus.imem_address    = addr_q;
    assign bus.imem_action_stb = (state != IDLE);
    assign bus.imem_action_cyc = (state != IDLE);
    assign bus.count           = count;
    assign bus.out_valid       = (count != '0) && !bus.redirect;
    assign bus.out_instr       = queue[rd_ptr].instr;
    assign bus.out_pc          = queue[rd_ptr].pc;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for the fetch prefetch queue: fill/saturate, single dequeue refill,
// redirect flush with DROP, redirect with resp, retry, address wrap and async reset.
module tb_fetch_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fetch_prefetch_queue_if #(.WORD_W(16), .DEPTH(4)) bus ();

    fetch_prefetch_queue #(.DEPTH(4), .WORD_W(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.imem_rdata  = 16'h0000;
        bus.imem_resp   = 1'b0;
        bus.imem_retry  = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_action_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", bus.imem_action_stb); end
        checks++; if (bus.imem_action_cyc !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%b exp=0", bus.imem_action_cyc); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.imem_address !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.imem_address); end
    endtask

    // Resp every cycle, decode stalled: four entries then the fetcher idles
    task automatic test_fill();
        logic [15:0] exp_addr [5] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
        apply_reset();
        step();
        checks++; if (bus.imem_action_stb !== 1'b1 || bus.imem_address !== 16'h0000) begin failures++; $display("FAIL fill_first_req got=%b/%h exp=1/0000", bus.imem_action_stb, bus.imem_address); end
        for (int i = 0; i < 4; i++) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = 16'hA000 | exp_addr[i];
            step();
            checks++; if (bus.count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i + 1); end
            if (i < 3) begin
                checks++; if (bus.imem_address !== exp_addr[i+1]) begin failures++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, bus.imem_address, exp_addr[i+1]); end
            end
        end
        checks++; if (bus.imem_action_stb !== 1'b0) begin failures++; $display("FAIL fill_stb_drop got=%b exp=0", bus.imem_action_stb); end
        step();
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_idle_resp_ignored got=%0d exp=4", bus.count); end
        bus.imem_resp = 1'b0;
        checks++; if (bus.out_pc !== 16'h0002 || bus.out_instr !== 16'hA000) begin failures++; $display("FAIL fill_head got=%h/%h exp=0002/a000", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_full_dequeue();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL deq_count got=%0d exp=3", bus.count); end
        checks++; if (bus.out_pc !== 16'h0004) begin failures++; $display("FAIL deq_head got=%h exp=0004", bus.out_pc); end
        step();
        checks++; if (bus.imem_action_stb !== 1'b1 || bus.imem_address !== 16'h0008) begin failures++; $display("FAIL deq_refetch got=%b/%h exp=1/0008", bus.imem_action_stb, bus.imem_address); end
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'hA008;
        step();
        bus.imem_resp = 1'b0;
        checks++; if (bus.count !== 3'd4 || bus.imem_action_stb !== 1'b0) begin failures++; $display("FAIL deq_refill got=%0d/%b exp=4/0", bus.count, bus.imem_action_stb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_pc !== 16'(4 + 2 * i) || bus.out_instr !== 16'(16'hA002 + 2 * i)) begin failures++; $display("FAIL drain[%0d] got=%h/%h exp=%h/%h", i, bus.out_pc, bus.out_instr, 16'(4 + 2 * i), 16'(16'hA002 + 2 * i)); end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_redirect_drop();
        apply_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h000C;
        step();
        bus.redirect  = 1'b0;
        bus.imem_resp = 1'b1;
        step();
        step();
        bus.imem_resp = 1'b0;
        checks++; if (bus.count !== 3'd2 || bus.imem_address !== 16'h0010) begin failures++; $display("FAIL drop_setup got=%0d/%h exp=2/0010", bus.count, bus.imem_address); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0041;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drop_valid_mask got=%b exp=0", bus.out_valid); end
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.imem_address !== 16'h0010 || bus.imem_action_stb !== 1'b1) begin failures++; $display("FAIL drop_flush got=%0d/%h/%b exp=0/0010/1", bus.count, bus.imem_address, bus.imem_action_stb); end
        step();
        checks++; if (bus.imem_address !== 16'h0010 || bus.imem_action_cyc !== 1'b1) begin failures++; $display("FAIL drop_hold got=%h/%b exp=0010/1", bus.imem_address, bus.imem_action_cyc); end
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        step();
        bus.imem_resp = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL drop_discard got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
        checks++; if (bus.imem_address !== 16'h0040 || bus.imem_action_stb !== 1'b1) begin failures++; $display("FAIL drop_reissue got=%h/%b exp=0040/1", bus.imem_address, bus.imem_action_stb); end
    endtask

    task automatic test_redirect_with_resp();
        bus.imem_resp   = 1'b1;
        bus.imem_rdata  = 16'hBEEF;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        step();
        idle_inputs();
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rdr_resp_discard got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
        checks++; if (bus.imem_address !== 16'h0100 || bus.imem_action_stb !== 1'b1) begin failures++; $display("FAIL rdr_resp_addr got=%h/%b exp=0100/1", bus.imem_address, bus.imem_action_stb); end
    endtask

    task automatic test_retry();
        apply_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0020;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_address !== 16'h0020) begin failures++; $display("FAIL retry_issue got=%h exp=0020", bus.imem_address); end
        bus.imem_retry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.imem_address !== 16'h0020 || bus.count !== 3'd0 || bus.imem_action_stb !== 1'b1) begin failures++; $display("FAIL retry_hold[%0d] got=%h/%0d/%b exp=0020/0/1", i, bus.imem_address, bus.count, bus.imem_action_stb); end
        end
        bus.imem_retry = 1'b0;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h1234;
        step();
        bus.imem_resp = 1'b0;
        checks++; if (bus.count !== 3'd1 || bus.out_pc !== 16'h0022 || bus.out_instr !== 16'h1234) begin failures++; $display("FAIL retry_enq got=%0d/%h/%h exp=1/0022/1234", bus.count, bus.out_pc, bus.out_instr); end
        checks++; if (bus.imem_address !== 16'h0022) begin failures++; $display("FAIL retry_next got=%h exp=0022", bus.imem_address); end
    endtask

    task automatic test_wrap_and_async_reset();
        apply_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_address !== 16'hFFFE) begin failures++; $display("FAIL wrap_bit0 got=%h exp=fffe", bus.imem_address); end
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h1111;
        step();
        checks++; if (bus.imem_address !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h exp=0000", bus.imem_address); end
        bus.imem_rdata = 16'h2222;
        step();
        bus.imem_resp = 1'b0;
        checks++; if (bus.count !== 3'd2 || bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h1111) begin failures++; $display("FAIL wrap_head0 got=%0d/%h/%h exp=2/0000/1111", bus.count, bus.out_pc, bus.out_instr); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_pc !== 16'h0002 || bus.out_instr !== 16'h2222) begin failures++; $display("FAIL wrap_head1 got=%h/%h exp=0002/2222", bus.out_pc, bus.out_instr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_action_stb !== 1'b0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.imem_address !== 16'h0000) begin failures++; $display("FAIL async_reset got=%b/%0d/%b/%h exp=0/0/0/0000", bus.imem_action_stb, bus.count, bus.out_valid, bus.imem_address); end
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.imem_action_stb !== 1'b1 || bus.imem_address !== 16'h0000) begin failures++; $display("FAIL reset_restart got=%b/%h exp=1/0000", bus.imem_action_stb, bus.imem_address); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_full_dequeue();
        test_redirect_drop();
        test_redirect_with_resp();
        test_retry();
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
